// File: rtl/bin2bcd_seq.sv
// Sequential binary to packed-BCD converter (shift-and-add-3), one shift per clock,
// with a leading-zero blanking mask for the downstream seven-segment scanner.
module bin2bcd_seq #(
  parameter int WIDTH  = 11,
  parameter int DIGITS = 8
) (
  input  logic                  CLK,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      Di,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [DIGITS*4-1:0]   show,
  output logic [DIGITS-1:0]     blank,
  output logic [1:0]            state_dbg
);

  // Handshake: start is level-sampled on every rising edge but accepted only while
  // busy=0; busy stays high from the accepting edge until the result edge, where
  // done pulses for one cycle and show/blank update. Requests while busy are dropped.

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  localparam int BCD_W = DIGITS * 4;
  localparam int SR_W  = BCD_W + WIDTH;
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0]  LAST_ITER = CNT_W'(WIDTH - 1);
  localparam logic [DIGITS-1:0] BLANK_RST = {{(DIGITS-1){1'b1}}, 1'b0};

  state_t              state_q, state_d;
  logic [SR_W-1:0]     sr_q, sr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [BCD_W-1:0]    show_q, show_d;
  logic [DIGITS-1:0]   blank_q, blank_d;
  logic                done_q, done_d;
  logic [SR_W-1:0]     sr_adj;
  logic [DIGITS-1:0]   blank_calc;
  logic                zero_run;

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_SHIFT;
      S_SHIFT:  if (cnt_q == LAST_ITER) state_d = S_FINISH;
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q != S_IDLE);
    done      = done_q;
    show      = show_q;
    blank     = blank_q;
    state_dbg = state_q;
  end

  // Add-3 correction on every BCD nibble of the current register, before the shift.
  always_comb begin
    sr_adj = sr_q;
    for (int d = 0; d < DIGITS; d++) begin
      if (sr_q[WIDTH+4*d +: 4] >= 4'd5)
        sr_adj[WIDTH+4*d +: 4] = sr_q[WIDTH+4*d +: 4] + 4'd3;
    end
  end

  // Leading-zero run from the top digit down; digit 0 is never blanked.
  always_comb begin
    zero_run   = 1'b1;
    blank_calc = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_run      = zero_run & (sr_q[WIDTH+4*i +: 4] == 4'd0);
      blank_calc[i] = zero_run;
    end
    blank_calc[0] = 1'b0;
  end

  always_comb begin
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    show_d  = show_q;
    blank_d = blank_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          sr_d  = {{BCD_W{1'b0}}, Di};
          cnt_d = '0;
        end
      end
      S_SHIFT: begin
        sr_d  = {sr_adj[SR_W-2:0], 1'b0};
        cnt_d = cnt_q + CNT_W'(1);
      end
      S_FINISH: begin
        show_d  = sr_q[SR_W-1:WIDTH];
        blank_d = blank_calc;
        done_d  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      sr_q    <= '0;
      cnt_q   <= '0;
      show_q  <= '0;
      blank_q <= BLANK_RST;
      done_q  <= 1'b0;
    end else begin
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      show_q  <= show_d;
      blank_q <= blank_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: directed cases plus a full sweep and random
// conversions, compared against decimal digits computed with plain arithmetic.
module tb_bin2bcd_seq;

  localparam int WIDTH  = 11;
  localparam int DIGITS = 8;
  localparam int RW     = DIGITS * 5;

  logic                CLK;
  logic                rst;
  logic [WIDTH-1:0]    Di;
  logic                start;
  logic                busy;
  logic                done;
  logic [DIGITS*4-1:0] show;
  logic [DIGITS-1:0]   blank;
  logic [1:0]          state_dbg;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned cyc = 0;
  logic [RW-1:0] exp_q[$];

  bin2bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .CLK(CLK), .rst(rst), .Di(Di), .start(start), .busy(busy), .done(done),
    .show(show), .blank(blank), .state_dbg(state_dbg)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference: decimal digits by repeated division; blank covers digits above the
  // most significant non-zero one (value 0 counts as one significant digit).
  function automatic logic [RW-1:0] model(input int unsigned v);
    logic [DIGITS*4-1:0] s;
    logic [DIGITS-1:0]   b;
    int unsigned t;
    int n;
    s = '0;
    t = v;
    n = 0;
    do begin
      s[4*n +: 4] = 4'(t % 10);
      t = t / 10;
      n++;
    end while (t > 0);
    b = '0;
    for (int i = n; i < DIGITS; i++) b[i] = 1'b1;
    return {b, s};
  endfunction

  // scoreboard: every done pops one expected result
  always @(negedge CLK) begin
    if (!rst && done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 64'(done), 64'd0);
      end else begin
        logic [RW-1:0] e;
        e = exp_q.pop_front();
        check("show",  64'(show),  64'(e[DIGITS*4-1:0]));
        check("blank", 64'(blank), 64'(e[RW-1:DIGITS*4]));
      end
    end
  end

  // drivers (called at a negedge)
  task automatic wait_done(input int unsigned t0, input int unsigned lat_exp);
    int n;
    n = 0;
    while (!done && n < 100) begin
      @(negedge CLK);
      n++;
    end
    if (!done) check("done_timeout", 64'd0, 64'd1);
    else       check("latency", 64'(cyc - t0), 64'(lat_exp));
  endtask

  task automatic convert(input logic [WIDTH-1:0] v);
    int unsigned t0;
    exp_q.push_back(model(v));
    Di    = v;
    start = 1'b1;
    @(negedge CLK);
    t0    = cyc;
    start = 1'b0;
    Di    = WIDTH'($urandom);
    check("busy_during", 64'(busy), 64'd1);
    wait_done(t0, 12);
    @(negedge CLK);
    check("done_single", 64'(done), 64'd0);
    check("busy_after_done", 64'(busy), 64'd0);
  endtask

  initial begin
    int unsigned t0, t1;
    rst   = 1'b1;
    start = 1'b0;
    Di    = '0;
    repeat (3) @(negedge CLK);
    check("rst_busy",  64'(busy),  64'd0);
    check("rst_done",  64'(done),  64'd0);
    check("rst_show",  64'(show),  64'd0);
    check("rst_blank", 64'(blank), 64'hFE);
    rst = 1'b0;
    @(negedge CLK);

    convert(11'd2047);
    convert(11'd0);

    // back-to-back with start held high
    exp_q.push_back(model(1000));
    exp_q.push_back(model(9));
    Di    = 11'd1000;
    start = 1'b1;
    @(negedge CLK);
    t0 = cyc;
    Di = 11'd9;
    wait_done(t0, 12);
    t1 = cyc;
    @(negedge CLK);
    start = 1'b0;
    t0 = cyc;
    Di = WIDTH'($urandom);
    wait_done(t0, 12);
    check("b2b_gap", 64'(cyc - t1), 64'd13);
    @(negedge CLK);

    // start while busy is ignored
    exp_q.push_back(model(1234));
    Di    = 11'd1234;
    start = 1'b1;
    @(negedge CLK);
    t0    = cyc;
    start = 1'b0;
    repeat (3) @(negedge CLK);
    Di    = 11'd5;
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    wait_done(t0, 12);
    repeat (20) @(negedge CLK);
    check("ignored_busy", 64'(busy), 64'd0);
    check("ignored_show", 64'(show), 64'h1234);

    // reset mid-conversion: no result expected
    Di    = 11'd777;
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    repeat (5) @(negedge CLK);
    rst = 1'b1;
    #1;
    check("midrst_show",  64'(show),  64'd0);
    check("midrst_blank", 64'(blank), 64'hFE);
    check("midrst_busy",  64'(busy),  64'd0);
    check("midrst_done",  64'(done),  64'd0);
    @(negedge CLK);
    rst = 1'b0;
    repeat (20) @(negedge CLK);
    check("postrst_busy", 64'(busy), 64'd0);
    check("postrst_show", 64'(show), 64'd0);
    convert(11'd777);

    // full sweep
    for (int v = 0; v < (1 << WIDTH); v++) convert(WIDTH'(v));

    // random values with random idle gaps
    for (int k = 0; k < 150; k++) begin
      repeat ($urandom_range(0, 3)) @(negedge CLK);
      convert(WIDTH'($urandom_range(0, (1 << WIDTH) - 1)));
    end

    repeat (5) @(negedge CLK);
    check("exp_q_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
- Sequential binary-to-packed-BCD converter using the shift-and-add-3 (double-dabble) method.
- Sits directly upstream of the 8-digit seven-segment scanner and feeds its 32-bit packed-digit input.
- Replaces the per-digit combinational divide/modulo chain with an iterative datapath of one shift per clock.
- Also produces a leading-zero blanking mask so the scanner can dark unused digits.

Parameters:
- WIDTH, 11, width of the binary input; also the number of shift iterations.
- DIGITS, 8, number of BCD digits produced. Must satisfy DIGITS*4 >= WIDTH and DIGITS >= ceil(WIDTH*log10(2)).

Ports:
- CLK  input  1  system clock, 100 MHz, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- Di  input  WIDTH  binary value to convert; sampled only on an accepted start
- start  input  1  conversion request; level sampled each rising edge
- busy  output  1  high while a conversion is in progress
- done  output  1  single-cycle pulse when show/blank update
- show  output  DIGITS*4  packed BCD; digit i at show[4i+3:4i], digit 0 is the least significant
- blank  output  DIGITS  bit i high means digit i is a leading zero; bit 0 is always 0

Behaviour:
- Reset (async, rst=1): state=IDLE, busy=0, done=0, show=0, blank={DIGITS-1{1'b1},1'b0} (8'hFE at default), iteration counter=0, shift register=0.
- States: IDLE, SHIFT, FINISH.
- IDLE: on an edge with start=1, latch Di into the low WIDTH bits of the shift register and clear its BCD field. Set counter=0, busy=1, go to SHIFT. If start=0, hold.
- SHIFT, one iteration per edge, two steps in order:
  - Every BCD nibble >= 5 gets +3, computed combinationally from the current register.
  - The whole {bcd,bin} register then shifts left by 1 and the counter increments.
  - After the iteration with counter==WIDTH-1, go to FINISH.
- FINISH, one edge:
  - Load show from the BCD field and compute blank.
  - Pulse done=1 for exactly one cycle, set busy=0, return to IDLE.
- Blank rule: scanning from digit DIGITS-1 downward, bit i=1 while digit i and all higher digits are 0. Bit 0 is forced 0, so value 0 shows a single "0".
- Latency: start accepted at edge k; WIDTH shifts at edges k+1..k+WIDTH; show/blank/done update at edge k+WIDTH+1 (k+12 at default). busy is high from edge k to edge k+WIDTH+1.
- start while busy=1 is ignored; no queueing. Di changes during a conversion have no effect.
- Back-to-back: start held high is accepted at the first edge after done asserts, i.e. one idle edge between conversions.
- show and blank hold their last values between conversions. The scanner never sees intermediate shift values.
- Width rule: each nibble is 4 bits. The add-3 carry can never exceed 4 bits given the DIGITS constraint. Unused high digits stay 0.
- Reset mid-conversion discards the conversion: the reset values apply immediately, and no done pulse follows release.
- After rst deasserts, the first accepted start behaves exactly as from power-up.

Test Plan:
- Reset then start with Di=2047 -> done exactly 12 cycles after the accepted edge, show=32'h0000_2047, blank=8'hF0, busy low after done.
- Di=0, start -> show=32'h0000_0000, blank=8'hFE.
- Di=1000, then Di=9 back-to-back with start held high -> show=32'h0000_1000 with blank=8'hF0; then show=32'h0000_0009 with blank=8'hFE. Second done follows 13 cycles after the first.
- Start Di=1234, then pulse start with Di=5 at cycle 4 while busy -> single done, show=32'h0000_1234; the second request is ignored.
- Start Di=777, assert rst at cycle 6 -> show=0, blank=8'hFE, busy=0, no done pulse. A fresh start with Di=777 gives show=32'h0000_0777, blank=8'hF8.
- Sweep all Di 0..2047 -> every show digit matches the decimal digits of Di, and every blank matches the leading-zero rule.
